lab3_mem_responder: RTL and testbench
=====================================

Name: lab3_mem_responder

Overview:
- Memory-side responder for the 4B val/rdy memory protocol. It is the far end of the cache's refill/write path.
- Accepts one mem_req_4B_t at a time and applies it to an internal word-addressed array after a programmable latency. Returns a mem_resp_4B_t.
- Used as the backing memory in cache unit and integration benches. A preload port initialises contents.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words in the array (power of two).
- LATENCY, 2, cycles from request accept edge to memresp_val high; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- memreq_val  input  1  request valid from cache.
- memreq_rdy  output  1  responder can accept a request.
- memreq_msg  input  77  mem_req_4B_t {type_[2:0], opaque[7:0], addr[31:0], len[1:0], data[31:0]}.
- memresp_val  output  1  response valid.
- memresp_rdy  input  1  cache can accept the response.
- memresp_msg  output  47  mem_resp_4B_t {type_[2:0], opaque[7:0], test[1:0], len[1:0], data[31:0]}.
- load_en  input  1  preload write strobe (bench use).
- load_addr  input  $clog2(MEM_WORDS)  preload word index.
- load_data  input  32  preload word.

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE, memresp_val=0, memresp_msg=0, latency counter=0, request register=0.
  - memreq_rdy=1 while in IDLE, including the cycle reset deasserts.
  - Array contents are NOT reset.
- States:
  - IDLE: memreq_rdy=1, memresp_val=0.
    - On memreq_val&&memreq_rdy at an edge, latch memreq_msg into the request register and load counter=LATENCY-1.
    - Go to WAIT if LATENCY>1, else to RESP.
  - WAIT: memreq_rdy=0, memresp_val=0.
    - Counter decrements each cycle.
    - When counter==1, the next edge performs the access and enters RESP.
  - RESP: memresp_val=1, memreq_rdy=0.
    - memresp_msg is held stable until memresp_val&&memresp_rdy at an edge, then go to IDLE.
- Latency: request accepted at edge t gives memresp_val high from edge t+LATENCY onward.
- Throughput:
  - No accept in the same cycle as a response handshake.
  - Minimum spacing between accepts is LATENCY+1 cycles.
- Access: performed on the edge entering RESP.
  - Word index = addr[$clog2(MEM_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo the array size.
  - READ (type_=0): resp.data = mem[index]. len and addr[1:0] are ignored for reads; the full word is returned.
  - WRITE (type_=1): bytes written start at byte addr[1:0].
    - Byte count is len==0 ? 4 : len.
    - Bytes beyond byte 3 are dropped (no spill into the next word).
    - Byte i of the write comes from data[8*i+7:8*i].
    - resp.data=0.
  - Any other type_: no array write, resp.data=0.
- Response fields: type_, opaque and len are copied from the request; test=2'b00.
- Preload: load_en writes mem[load_addr]=load_data at the edge, in any state.
  - If load and a protocol WRITE hit the same word on the same edge, load_data wins.
  - A READ on the same edge returns the pre-edge value.
- Backpressure: memresp_rdy=0 holds RESP indefinitely; memresp_msg must not change.
- Reset mid-operation: any in-flight request is dropped with no array write. If reset asserts on or after the commit edge, the write already done persists.
- memreq_val while not in IDLE: ignored, not latched.

Test Plan:
- Preload mem[5]=32'hDEADBEEF; READ addr=0x14, opaque=8'h3C, LATENCY=2 -> memresp_val rises 2 edges after accept; data=0xDEADBEEF, opaque=0x3C, type_=0, test=0.
- WRITE addr=0x20, len=0, data=0x12345678, then READ 0x20 -> write resp data=0; read returns 0x12345678.
- Preload mem[8]=0xAABBCCDD; WRITE addr=0x21, len=2, data=0x0000EEFF; READ 0x20 -> 0xAAEEFFDD. Then WRITE addr=0x23, len=3, data=0x00000011 -> 0x11EEFFDD (overflow bytes dropped).
- Hold memresp_rdy=0 for 5 cycles with memreq_val=1 throughout -> memresp_msg constant, memreq_rdy=0; a single handshake after rdy rises, then the next request is accepted.
- LATENCY=1: back-to-back READs with memresp_rdy=1 -> accepts on every other cycle; each response appears 1 edge after its accept.
- Assert reset during WAIT of a WRITE to 0x40 (mem[16] preloaded 0x1) -> memresp_val=0 immediately, memreq_rdy=1 after deassert, READ 0x40 returns 0x1.

Source files
------------

// File: rtl/lab3_mem_responder.sv
// lab3_mem_responder: backing memory for the 4B val/rdy memory protocol.
// Accepts one request at a time, applies it to a word array after a
// fixed latency and returns a response held until the cache takes it.
//
// Ports:
//   clk, reset            clock, async active-high reset
//   memreq_val/rdy/msg    request channel (mem_req_4B_t, 77 bits)
//   memresp_val/rdy/msg   response channel (mem_resp_4B_t, 47 bits)
//   load_en/addr/data     preload write port, usable in any state
module lab3_mem_responder #(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         memreq_val,
    output logic                         memreq_rdy,
    input  logic [76:0]                  memreq_msg,
    output logic                         memresp_val,
    input  logic                         memresp_rdy,
    output logic [46:0]                  memresp_msg,
    input  logic                         load_en,
    input  logic [$clog2(MEM_WORDS)-1:0] load_addr,
    input  logic [31:0]                  load_data
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    localparam logic [2:0] T_READ  = 3'd0;
    localparam logic [2:0] T_WRITE = 3'd1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [76:0] req_q, req_d;
    logic [46:0] resp_q, resp_d;

    logic [31:0] mem [MEM_WORDS];

    // Request being committed this cycle: the live input when the
    // accept edge is also the commit edge (LATENCY==1), else the latch.
    logic          acc_en;
    logic [76:0]   acc_msg;
    logic [2:0]    acc_type;
    logic [7:0]    acc_opq;
    logic [1:0]    acc_len;
    logic [31:0]   acc_data;
    logic [1:0]    acc_off;
    logic [AW-1:0] acc_idx;
    logic          unused_addr_hi;

    assign acc_type = acc_msg[76:74];
    assign acc_opq  = acc_msg[73:66];
    assign acc_off  = acc_msg[35:34];
    assign acc_idx  = acc_msg[AW+35:36];
    assign acc_len  = acc_msg[33:32];
    assign acc_data = acc_msg[31:0];

    // Upper address bits do not select a word; the array wraps.
    assign unused_addr_hi = ^acc_msg[65:AW+36];

    // Byte-lane write: bytes shifted past lane 3 fall off the word.
    logic [3:0]  base_mask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic        wr_en;

    always_comb begin
        base_mask = 4'hF;
        unique case (acc_len)
            2'd1:    base_mask = 4'h1;
            2'd2:    base_mask = 4'h3;
            2'd3:    base_mask = 4'h7;
            default: base_mask = 4'hF;
        endcase
    end

    assign wmask = base_mask << acc_off;
    assign wdata = acc_data << {acc_off, 3'b000};
    assign wr_en = acc_en && (acc_type == T_WRITE) && !reset;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        resp_d  = resp_q;
        acc_en  = 1'b0;
        acc_msg = req_q;

        unique case (state_q)
            S_IDLE: begin
                if (memreq_val) begin
                    req_d = memreq_msg;
                    cnt_d = LAT_M1;
                    if (LATENCY > 1) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_RESP;
                        acc_en  = 1'b1;
                        acc_msg = memreq_msg;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd1) begin
                    cnt_d   = 4'd0;
                    acc_en  = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (memresp_rdy) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Reads sample the array before this edge's writes land.
        if (acc_en) begin
            resp_d = {acc_type, acc_opq, 2'b00, acc_len,
                      (acc_type == T_READ) ? mem[acc_idx] : 32'h0};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            req_q   <= '0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            resp_q  <= resp_d;
        end
    end

    // Array has no reset. Preload is applied last so it wins a
    // same-word collision with a protocol write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask[b]) begin
                    mem[acc_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    assign memreq_rdy  = (state_q == S_IDLE);
    assign memresp_val = (state_q == S_RESP);
    assign memresp_msg = resp_q;

endmodule

// File: tb/tb_lab3_mem_responder.sv
// tb_lab3_mem_responder: directed scoreboard bench for lab3_mem_responder.
// Instance u_dut uses LATENCY=2, u_dut1 uses LATENCY=1.
module tb_lab3_mem_responder;

    logic        clk = 1'b0;
    logic        reset;

    logic        req_val, req_rdy, resp_val, resp_rdy;
    logic [76:0] req_msg;
    logic [46:0] resp_msg;
    logic        load_en;
    logic [9:0]  load_addr;
    logic [31:0] load_data;

    logic        req_val1, req_rdy1, resp_val1, resp_rdy1;
    logic [76:0] req_msg1;
    logic [46:0] resp_msg1;
    logic        load_en1;
    logic [9:0]  load_addr1;
    logic [31:0] load_data1;

    int nvec  = 0;
    int nfail = 0;
    logic [46:0] sbq[$];

    always #5 clk = ~clk;

    lab3_mem_responder #(.MEM_WORDS(1024), .LATENCY(2)) u_dut (
        .clk(clk), .reset(reset),
        .memreq_val(req_val), .memreq_rdy(req_rdy), .memreq_msg(req_msg),
        .memresp_val(resp_val), .memresp_rdy(resp_rdy), .memresp_msg(resp_msg),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    lab3_mem_responder #(.MEM_WORDS(1024), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .memreq_val(req_val1), .memreq_rdy(req_rdy1), .memreq_msg(req_msg1),
        .memresp_val(resp_val1), .memresp_rdy(resp_rdy1), .memresp_msg(resp_msg1),
        .load_en(load_en1), .load_addr(load_addr1), .load_data(load_data1)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [76:0] mkreq(input logic [2:0] t, input logic [7:0] o,
                                          input logic [31:0] a, input logic [1:0] l,
                                          input logic [31:0] d);
        return {t, o, a, l, d};
    endfunction

    function automatic logic [46:0] mkresp(input logic [2:0] t, input logic [7:0] o,
                                           input logic [1:0] l, input logic [31:0] d);
        return {t, o, 2'b00, l, d};
    endfunction

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    // Drive a request on u_dut until it is accepted; queue its response.
    task automatic send(input logic [2:0] t, input logic [7:0] o,
                        input logic [31:0] a, input logic [1:0] l,
                        input logic [31:0] d, input logic [31:0] exp_data);
        int n;
        n = 0;
        req_msg = mkreq(t, o, a, l, d);
        req_val = 1'b1;
        while (!req_rdy && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("req_rdy_before_accept", 64'(req_rdy), 64'd1);
        @(posedge clk); #1;
        req_val = 1'b0;
        sbq.push_back(mkresp(t, o, l, exp_data));
    endtask

    // Called #1 after the accept edge; k counts edges from accept to
    // the first edge that sees memresp_val high.
    task automatic get_resp(input string tag, input int exp_lat);
        int k;
        logic [46:0] e;
        k = 1;
        while (!resp_val && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check({tag, "_lat"}, 64'(k), 64'(exp_lat));
        e = (sbq.size() > 0) ? sbq.pop_front() : 'x;
        check({tag, "_msg"}, 64'(resp_msg), 64'(e));
        resp_rdy = 1'b1;
        @(posedge clk); #1;
        resp_rdy = 1'b0;
        check({tag, "_idle"}, 64'({resp_val, req_rdy}), 64'(2'b01));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [46:0] held;
        logic [46:0] e;
        int n;

        reset = 1'b1;
        req_val = 1'b0; req_msg = '0; resp_rdy = 1'b0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        req_val1 = 1'b0; req_msg1 = '0; resp_rdy1 = 1'b0;
        load_en1 = 1'b0; load_addr1 = '0; load_data1 = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_resp_val", 64'(resp_val), 64'd0);
        check("rst_resp_msg", 64'(resp_msg), 64'd0);
        check("rst_req_rdy", 64'(req_rdy), 64'd1);
        check("rst_resp_msg1", 64'(resp_msg1), 64'd0);
        reset = 1'b0;
        check("rst_release_rdy", 64'(req_rdy), 64'd1);

        // LATENCY=1: back-to-back reads, accepts on every other cycle
        for (int i = 0; i < 4; i++) begin
            load_en1   = 1'b1;
            load_addr1 = 10'(i);
            load_data1 = 32'hB000_0000 + 32'(i);
            @(posedge clk); #1;
        end
        load_en1  = 1'b0;
        resp_rdy1 = 1'b1;
        req_val1  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("l1_idle", 64'({resp_val1, req_rdy1}), 64'(2'b01));
            req_msg1 = mkreq(3'd0, 8'h80 + 8'(i), 32'(i * 4), 2'd0, 32'h0);
            sbq.push_back(mkresp(3'd0, 8'h80 + 8'(i), 2'd0,
                                 32'hB000_0000 + 32'(i)));
            @(posedge clk); #1;
            check("l1_resp", 64'({resp_val1, req_rdy1}), 64'(2'b10));
            e = sbq.pop_front();
            check("l1_msg", 64'(resp_msg1), 64'(e));
            @(posedge clk); #1;
        end
        req_val1  = 1'b0;
        resp_rdy1 = 1'b0;

        // Basic read with latency 2
        preload(10'd5, 32'hDEADBEEF);
        send(3'd0, 8'h3C, 32'h14, 2'd0, 32'h0, 32'hDEADBEEF);
        get_resp("read5", 2);

        // Full-word write then read back
        send(3'd1, 8'h01, 32'h20, 2'd0, 32'h12345678, 32'h0);
        get_resp("wr_full", 2);
        send(3'd0, 8'h02, 32'h20, 2'd0, 32'h0, 32'h12345678);
        get_resp("rd_full", 2);

        // Partial writes, including bytes that overflow past lane 3
        preload(10'd8, 32'hAABBCCDD);
        preload(10'd9, 32'h55667788);
        send(3'd1, 8'h03, 32'h21, 2'd2, 32'h0000EEFF, 32'h0);
        get_resp("wr_len2", 2);
        send(3'd0, 8'h04, 32'h20, 2'd1, 32'h0, 32'hAAEEFFDD);
        get_resp("rd_len2", 2);
        send(3'd1, 8'h05, 32'h23, 2'd3, 32'h00000011, 32'h0);
        get_resp("wr_ovf", 2);
        send(3'd0, 8'h06, 32'h20, 2'd0, 32'h0, 32'h11EEFFDD);
        get_resp("rd_ovf", 2);
        send(3'd0, 8'h07, 32'h24, 2'd0, 32'h0, 32'h55667788);
        get_resp("rd_next_word", 2);

        // Unknown type: no write, zero data; address wraps
        send(3'd2, 8'h55, 32'h14, 2'd0, 32'hCAFEF00D, 32'h0);
        get_resp("type2", 2);
        send(3'd0, 8'h56, 32'h1014, 2'd0, 32'h0, 32'hDEADBEEF);
        get_resp("rd_wrap", 2);

        // Backpressure with a competing request held valid
        send(3'd0, 8'h7E, 32'h14, 2'd0, 32'h0, 32'hDEADBEEF);
        req_msg = mkreq(3'd0, 8'h7F, 32'h20, 2'd0, 32'h0);
        req_val = 1'b1;
        n = 0;
        while (!resp_val && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        e = sbq.pop_front();
        held = resp_msg;
        check("bp_msg", 64'(held), 64'(e));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_hold_msg", 64'(resp_msg), 64'(e));
            check("bp_hold_flags", 64'({resp_val, req_rdy}), 64'(2'b10));
        end
        resp_rdy = 1'b1;
        @(posedge clk); #1;
        resp_rdy = 1'b0;
        check("bp_release", 64'({resp_val, req_rdy}), 64'(2'b01));
        @(posedge clk); #1;
        req_val = 1'b0;
        check("bp_next_accept", 64'({resp_val, req_rdy}), 64'(2'b00));
        sbq.push_back(mkresp(3'd0, 8'h7F, 2'd0, 32'h11EEFFDD));
        get_resp("bp_next", 2);

        // Reset while a write is waiting: the write is dropped
        preload(10'd16, 32'h00000001);
        check("rw_rdy", 64'(req_rdy), 64'd1);
        req_msg = mkreq(3'd1, 8'h40, 32'h40, 2'd0, 32'hFFFFFFFF);
        req_val = 1'b1;
        @(posedge clk); #1;
        req_val = 1'b0;
        check("rw_in_wait", 64'({resp_val, req_rdy}), 64'(2'b00));
        reset = 1'b1;
        #1;
        check("rw_rst_val", 64'(resp_val), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        check("rw_after_rst", 64'({resp_val, req_rdy}), 64'(2'b01));
        send(3'd0, 8'h41, 32'h40, 2'd0, 32'h0, 32'h00000001);
        get_resp("rw_read", 2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
